shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer.sv | 122 ++++++++++++
 tb/tb_shift_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle 4-bit shifter. A start pulse in IDLE captures the operand,
//   opcode and distance. The shift then runs at up to 3 bits per cycle, and
//   the FSM finishes with a one-cycle done pulse.
//
//   Build option: define SHIFTSEQ_ROTATE_EN to enable opcode 0100 (ROL).
//   Without it, 0100 is an illegal opcode like 0101-1111.
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request, sampled only in IDLE
//   opcode  in   [3:0] 0000/0001 LSL, 0010 LSR, 0011 ASR, 0100 ROL (optional)
//   data_in in   [3:0] operand
//   amount  in   [3:0] shift distance 0-15
//   busy    out  high whenever the FSM is not in IDLE
//   done    out  one-cycle completion pulse
//   result  out  [3:0] working register, held in IDLE
//   err     out  illegal-opcode flag, valid with done and held with result
module shift_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic [3:0] data_in,
  input  logic [3:0] amount,
  output logic       busy,
  output logic       done,
  output logic [3:0] result,
  output logic       err
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state, state_next;
  logic [3:0] work, work_next;
  logic [3:0] op, op_next;
  logic [3:0] remaining, remaining_next;
  logic       err_reg, err_next;
  logic       legal;
  logic [1:0] step;
  logic [7:0] rot;

  // Opcode legality is decided on the live input, because it only matters
  // on the capture edge.
  always_comb begin
    legal = 1'b0;
    case (opcode)
      4'b0000, 4'b0001, 4'b0010, 4'b0011: legal = 1'b1;
`ifdef SHIFTSEQ_ROTATE_EN
      4'b0100: legal = 1'b1;
`endif
      default: legal = 1'b0;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work      <= 4'b0000;
      op        <= 4'b0000;
      remaining <= 4'b0000;
      err_reg   <= 1'b0;
    end else begin
      state     <= state_next;
      work      <= work_next;
      op        <= op_next;
      remaining <= remaining_next;
      err_reg   <= err_next;
    end
  end

  // Next-state and datapath logic.
  // An illegal opcode loads zero into the working register, so the result
  // reads 0000 during DONE without a separate output mux.
  always_comb begin
    state_next     = state;
    work_next      = work;
    op_next        = op;
    remaining_next = remaining;
    err_next       = err_reg;
    step           = (remaining > 4'd3) ? 2'd3 : remaining[1:0];
    rot            = {work, work} << step;

    case (state)
      IDLE: begin
        if (start) begin
          op_next        = opcode;
          err_next       = !legal;
          work_next      = legal ? data_in : 4'b0000;
          remaining_next = legal ? amount : 4'b0000;
          state_next     = (legal && amount != 4'd0) ? SHIFT : DONE;
        end
      end

      SHIFT: begin
        case (op)
          4'b0000, 4'b0001: work_next = work << step;
          4'b0010:          work_next = work >> step;
          4'b0011:          work_next = 4'($signed(work) >>> step);
`ifdef SHIFTSEQ_ROTATE_EN
          4'b0100:          work_next = rot[7:4];
`endif
          default:          work_next = work;
        endcase
        remaining_next = remaining - {2'b00, step};
        if (remaining <= 4'd3) state_next = DONE;
      end

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign result = work;
  assign err    = err_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer
//   Directed bench for shift_sequencer. Each operation pushes its expected
//   {err, result} into a scoreboard queue. The entry is popped and compared
//   when done is seen. The bench also checks busy, latency, the hold
//   behaviour, start-ignore and asynchronous reset.
module tb_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] opcode;
  logic [3:0] data_in;
  logic [3:0] amount;
  logic       busy;
  logic       done;
  logic [3:0] result;
  logic       err;

  int vectors;
  int miscompares;
  logic [4:0] sb_q[$];

  shift_sequencer dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .opcode (opcode),
    .data_in(data_in),
    .amount (amount),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic bit is_legal(input logic [3:0] op);
    if (op <= 4'd3) return 1'b1;
`ifdef SHIFTSEQ_ROTATE_EN
    if (op == 4'd4) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Reference behaviour computed from the whole distance at once.
  function automatic logic [4:0] model(input logic [3:0] op, input logic [3:0] d,
                                       input logic [3:0] amt);
    logic [3:0]        r;
    logic signed [3:0] s;
    logic [7:0]        d2;
    int                k;
    r  = 4'b0000;
    s  = d;
    d2 = {d, d};
    k  = int'(amt) % 4;
    if (!is_legal(op)) return {1'b1, 4'b0000};
    case (op)
      4'd0, 4'd1: r = (amt >= 4) ? 4'b0000 : 4'(d << amt);
      4'd2:       r = (amt >= 4) ? 4'b0000 : 4'(d >> amt);
      4'd3:       r = (amt >= 4) ? {4{d[3]}} : 4'(s >>> amt);
      default:    r = 4'(d2 >> (4 - k));
    endcase
    return {1'b0, r};
  endfunction

  // Runs one operation end to end. If poke_shift is set, a conflicting
  // start is pulsed in the first busy cycle. A start is always pulsed
  // during DONE to show that it is ignored there too.
  task automatic apply_stimulus(input string tag, input logic [3:0] op,
                                input logic [3:0] d, input logic [3:0] amt,
                                input bit poke_shift);
    logic [4:0] exp;
    int         n;
    int         exp_shifts;
    exp_shifts = (is_legal(op) && amt != 0) ? (int'(amt) + 2) / 3 : 0;
    opcode  = op;
    data_in = d;
    amount  = amt;
    start   = 1'b1;
    sb_q.push_back(model(op, d, amt));
    tick();
    start   = poke_shift;
    opcode  = 4'd2;
    data_in = ~d;
    amount  = 4'd1;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      check_output({tag, "_busy"}, {7'd0, busy}, 8'd1);
      tick();
      start = 1'b0;
      n++;
    end
    if (done !== 1'b1) begin
      check_output({tag, "_timeout"}, {7'd0, done}, 8'd1);
    end else begin
      check_output({tag, "_shifts"}, 8'(n), 8'(exp_shifts));
      check_output({tag, "_busy_done"}, {7'd0, busy}, 8'd1);
      if (sb_q.size() == 0) begin
        check_output({tag, "_sb_empty"}, 8'd0, 8'd1);
      end else begin
        exp = sb_q.pop_front();
        check_output({tag, "_result"}, {4'd0, result}, {4'd0, exp[3:0]});
        check_output({tag, "_err"}, {7'd0, err}, {7'd0, exp[4]});
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      check_output({tag, "_idle_busy"}, {6'd0, busy, done}, 8'd0);
      check_output({tag, "_hold"}, {3'd0, err, result}, {3'd0, exp});
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    opcode  = 4'd0;
    data_in = 4'd0;
    amount  = 4'd0;
    tick();
    tick();
    check_output("reset_state", {2'd0, busy, done, result}, 8'd0);
    check_output("reset_err", {7'd0, err}, 8'd0);
    rst_n = 1'b1;
    tick();

    apply_stimulus("lsl_0011_by1", 4'd0, 4'b0011, 4'd1, 1'b0);
    apply_stimulus("asr_1000_by7", 4'd3, 4'b1000, 4'd7, 1'b1);
    apply_stimulus("lsr_1011_by0", 4'd2, 4'b1011, 4'd0, 1'b0);
    apply_stimulus("illegal_1010", 4'b1010, 4'b1011, 4'd3, 1'b0);
    apply_stimulus("rol_1001_by5", 4'd4, 4'b1001, 4'd5, 1'b0);
    apply_stimulus("lsl1_0101_by3", 4'd1, 4'b0101, 4'd3, 1'b0);
    apply_stimulus("lsr_1111_by2", 4'd2, 4'b1111, 4'd2, 1'b0);
    apply_stimulus("lsr_1111_by4", 4'd2, 4'b1111, 4'd4, 1'b0);
    apply_stimulus("asr_0110_by15", 4'd3, 4'b0110, 4'd15, 1'b0);
    apply_stimulus("asr_1010_by2", 4'd3, 4'b1010, 4'd2, 1'b1);
    apply_stimulus("lsl_1111_by9", 4'd0, 4'b1111, 4'd9, 1'b0);
    apply_stimulus("illegal_1111", 4'b1111, 4'b0110, 4'd0, 1'b0);

    // Abort an LSL by 9 during its second SHIFT cycle.
    opcode  = 4'd0;
    data_in = 4'b0101;
    amount  = 4'd9;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_output("abort_busy_before", {7'd0, busy}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort_async_zero", {2'd0, busy, done, result}, 8'd0);
    check_output("abort_async_err", {7'd0, err}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("abort_no_done", {6'd0, busy, done}, 8'd0);
    end
    rst_n = 1'b1;
    tick();
    apply_stimulus("post_reset_lsr", 4'd2, 4'b1100, 4'd2, 1'b0);

    check_output("sb_drained", 8'(sb_q.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
